uart_aes_block_seq: RTL
=======================

Name: uart_aes_block_seq

Overview:
- Sequencer between the UART byte streams and the AES core.
- Collects 16 received UART bytes into one 128-bit block and presents it to the AES core.
- Waits for the AES result, then serialises the 128-bit result back to the UART transmitter, one byte at a time.
- Provides an inter-byte timeout, so a partial block from a stalled sender is discarded instead of corrupting the next block.

Parameters:
TIMEOUT_W, 24, width of the inter-byte timeout counter and of the timeout port.
CNT_W, 16, width of the completed-block counter.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Rst  input  1  asynchronous, active-low reset (asserted when 0); clears all state.
En  input  1  block enable; when 0, acts as a synchronous clear to the COLLECT state.
rx_tdata  input  8  byte from the UART receiver stream.
rx_tvalid  input  1  rx byte valid.
rx_tready  output  1  sequencer accepts an rx byte.
tx_tdata  output  8  byte to the UART transmitter stream.
tx_tvalid  output  1  tx byte valid.
tx_tready  input  1  UART transmitter accepts the byte.
aes_in_data  output  128  block to the AES core.
aes_in_valid  output  1  block valid.
aes_in_ready  input  1  AES core accepts the block.
aes_out_data  input  128  AES result.
aes_out_valid  input  1  result valid.
aes_out_ready  output  1  sequencer accepts the result.
timeout  input  TIMEOUT_W  inter-byte timeout in Clk cycles; 0 disables the timeout.
busy  output  1  1 in any state other than COLLECT with byte count 0.
timeout_err  output  1  one-cycle pulse when a partial block is discarded.
blk_count  output  CNT_W  number of completed blocks; wraps modulo 2^CNT_W.

Behaviour:
- Reset (Rst=0, asynchronous) forces the following, all held while Rst=0:
  - state=COLLECT, byte_cnt=0, idle_cnt=0, data register=0, blk_count=0.
  - All valid/ready outputs, timeout_err, busy, tx_tdata and aes_in_data are 0.
- Handshake rule: a transfer occurs on a rising edge where valid=1 and ready=1.
- Valid-hold rule: once asserted, a valid stays high and its data stays stable until the transfer occurs (except when En=0 or Rst=0).
- COLLECT state:
  - rx_tready=1.
  - Each rx transfer writes the byte into the 128-bit register, MSB-first: byte k (0..15) goes to bits [127-8k -: 8], and byte_cnt increments.
  - On the 16th transfer, the next state is LOAD and byte_cnt becomes 0.
  - No bytes are lost and there are no bubbles; one byte per cycle is sustainable.
- LOAD state:
  - aes_in_valid=1, aes_in_data=register, rx_tready=0.
  - On the aes_in transfer, the next state is WAIT.
- WAIT state:
  - aes_out_ready=1.
  - On the aes_out transfer, aes_out_data is captured into the register and the next state is EMIT.
  - A result presented during LOAD is not accepted (aes_out_ready=0 outside WAIT).
- EMIT state:
  - tx_tvalid=1, tx_tdata=register[127:120].
  - On each tx transfer, the register shifts left by 8 and byte_cnt increments.
  - After the 16th transfer: blk_count increments, the next state is COLLECT, and tx_tvalid=0 in the following cycle.
  - rx_tready=0 throughout, so bytes arriving during LOAD/WAIT/EMIT are back-pressured by the UART receiver path.
- Latency:
  - 16th rx byte accepted at cycle N → aes_in_valid=1 at cycle N+1.
  - aes_out transfer at cycle M → tx_tvalid=1 at cycle M+1.
- Timeout (COLLECT only, byte_cnt>0, timeout≠0):
  - idle_cnt increments each cycle without an rx transfer and clears on a transfer.
  - When idle_cnt reaches timeout-1 with no transfer in that cycle, the following happens in the next cycle:
    - byte_cnt=0, idle_cnt=0, timeout_err=1 for exactly one cycle.
    - The register is not cleared; it is overwritten by the next block.
  - Simultaneous rx transfer and terminal count: the transfer wins; no timeout, idle_cnt clears.
  - timeout=0 or byte_cnt=0: idle_cnt is held at 0.
- En=0 (synchronous): same clear as reset except blk_count is kept. All valids/readies are 0 while En=0.
  - Abort mid-LOAD/EMIT is permitted; the AES core and UART drop any partial transaction themselves.
- Reset mid-operation: any state returns immediately to COLLECT with outputs at their reset values.
- Wrap: blk_count at 2^CNT_W-1 plus one block → 0.

Test Plan:
- Stream bytes 0x00..0x0F back-to-back, aes_in_ready=1 → aes_in_valid one cycle after the last byte; aes_in_data=0x000102030405060708090A0B0C0D0E0F.
- AES model returns 0x69C4E0D86A7B0430D8CDB78070B4C55A; tx_tready toggles 1,0,1,0 → tx bytes 0x69,0xC4,...,0x5A in order; blk_count=1; busy returns to 0.
- timeout=100; send 5 bytes then idle → timeout_err pulses once 100 cycles after the 5th byte; the next 16 bytes form a clean block equal to the sent bytes.
- Byte arrives exactly at the terminal idle cycle → no timeout_err; block completes normally.
- Rst pulled low during EMIT after 7 bytes → tx_tvalid=0 asynchronously, blk_count=0; after release, a new 16-byte block processes correctly.
- aes_out_valid held high during LOAD with aes_in_ready=0 for 20 cycles → not consumed until WAIT; exactly one tx block emitted.

Source files
------------

// File: rtl/uart_aes_block_seq.sv
// Block sequencer between the UART byte streams and an AES core: gathers 16 rx
// bytes into a 128-bit block, hands it to AES, then streams the result to tx.
module uart_aes_block_seq #(
    parameter int unsigned TIMEOUT_W = 24,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 En,
    input  logic [7:0]           rx_tdata,
    input  logic                 rx_tvalid,
    output logic                 rx_tready,
    output logic [7:0]           tx_tdata,
    output logic                 tx_tvalid,
    input  logic                 tx_tready,
    output logic [127:0]         aes_in_data,
    output logic                 aes_in_valid,
    input  logic                 aes_in_ready,
    input  logic [127:0]         aes_out_data,
    input  logic                 aes_out_valid,
    output logic                 aes_out_ready,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     blk_count
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_LOAD,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t               state_q, state_nxt;
    logic [IDX_W-1:0]     cnt_q, cnt_nxt;
    logic [TIMEOUT_W-1:0] idle_q, idle_nxt;
    logic [BLK_W-1:0]     data_q, data_nxt;
    logic [CNT_W-1:0]     blk_q, blk_nxt;
    logic                 err_q, err_nxt;
    logic                 rx_rdy_q, rx_rdy_nxt;
    logic                 in_vld_q, in_vld_nxt;
    logic                 out_rdy_q, out_rdy_nxt;
    logic                 tx_vld_q, tx_vld_nxt;
    logic                 busy_q, busy_nxt;

    logic rx_fire, in_fire, out_fire, tx_fire;

    // Handshake strobes use the externally visible (En-gated) valid/ready
    assign rx_fire  = rx_tvalid & rx_tready;
    assign in_fire  = aes_in_valid & aes_in_ready;
    assign out_fire = aes_out_valid & aes_out_ready;
    assign tx_fire  = tx_tvalid & tx_tready;

    // State register and registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_COLLECT;
            cnt_q     <= '0;
            idle_q    <= '0;
            data_q    <= '0;
            blk_q     <= '0;
            err_q     <= 1'b0;
            rx_rdy_q  <= 1'b0;
            in_vld_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            idle_q    <= idle_nxt;
            data_q    <= data_nxt;
            blk_q     <= blk_nxt;
            err_q     <= err_nxt;
            rx_rdy_q  <= rx_rdy_nxt;
            in_vld_q  <= in_vld_nxt;
            out_rdy_q <= out_rdy_nxt;
            tx_vld_q  <= tx_vld_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next-state, datapath and output lookahead
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idle_nxt  = idle_q;
        data_nxt  = data_q;
        blk_nxt   = blk_q;
        err_nxt   = 1'b0;

        if (!En) begin
            state_nxt = S_COLLECT;
            cnt_nxt   = '0;
            idle_nxt  = '0;
            data_nxt  = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (rx_fire) begin
                        data_nxt[{LAST_IDX - cnt_q, 3'b000} +: BYTE_W] = rx_tdata;
                        idle_nxt = '0;
                        if (cnt_q == LAST_IDX) begin
                            cnt_nxt   = '0;
                            state_nxt = S_LOAD;
                        end else begin
                            cnt_nxt = cnt_q + IDX_W'(1);
                        end
                    end else if ((cnt_q != '0) && (timeout != '0)) begin
                        // Stalled sender: drop the partial block, keep the data bits
                        if (idle_q == (timeout - TIMEOUT_W'(1))) begin
                            cnt_nxt  = '0;
                            idle_nxt = '0;
                            err_nxt  = 1'b1;
                        end else begin
                            idle_nxt = idle_q + TIMEOUT_W'(1);
                        end
                    end else begin
                        idle_nxt = '0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (out_fire) begin
                        data_nxt  = aes_out_data;
                        state_nxt = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tx_fire) begin
                        data_nxt = {data_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
                        if (cnt_q == LAST_IDX) begin
                            cnt_nxt   = '0;
                            blk_nxt   = blk_q + CNT_W'(1);
                            state_nxt = S_COLLECT;
                        end else begin
                            cnt_nxt = cnt_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = S_COLLECT;
                    cnt_nxt   = '0;
                    idle_nxt  = '0;
                end
            endcase
        end

        rx_rdy_nxt  = En && (state_nxt == S_COLLECT);
        in_vld_nxt  = En && (state_nxt == S_LOAD);
        out_rdy_nxt = En && (state_nxt == S_WAIT);
        tx_vld_nxt  = En && (state_nxt == S_EMIT);
        busy_nxt    = !((state_nxt == S_COLLECT) && (cnt_nxt == '0));
    end

    // En gating keeps every handshake low in the very cycle En drops
    assign rx_tready     = rx_rdy_q & En;
    assign aes_in_valid  = in_vld_q & En;
    assign aes_out_ready = out_rdy_q & En;
    assign tx_tvalid     = tx_vld_q & En;
    assign tx_tdata      = data_q[BLK_W-1 -: BYTE_W];
    assign aes_in_data   = data_q;
    assign busy          = busy_q;
    assign timeout_err   = err_q;
    assign blk_count     = blk_q;

endmodule
